// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file geometry and the
// register-file state encoding. Also imported by ALU and control blocks.
package cpu_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;

   // Architectural zero register address
   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      RF_INIT,
      RF_READY
   } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   state   - register-file state; reads return 0 while clearing
//   r_reg   - read address
//   wr_en   - write enable presented this cycle (for bypass)
//   w_reg   - write address presented this cycle
//   w_data  - write data presented this cycle
//   regs    - register array contents
//   r_data  - read data
module rf_read_port
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS
) (
   input  rf_state_t         state,
   input  logic [ADDR_W-1:0] r_reg,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] w_reg,
   input  logic [DATA_W-1:0] w_data,
   input  logic [DATA_W-1:0] regs [NUM_REGS],
   output logic [DATA_W-1:0] r_data
);

   always_comb begin
      r_data = '0;
      if (state == RF_READY) begin
         if (r_reg == ADDR_W'(ZERO_REG)) begin
            r_data = '0;
         end else if (wr_en && (w_reg == r_reg)) begin
            // Same-cycle bypass: the write is visible before it lands
            r_data = w_data;
         end else begin
            r_data = regs[r_reg];
         end
      end
   end

endmodule

// File: rtl/reg_file_main.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, same-cycle write-to-read bypass. The array
// has no parallel reset; after reset an init sequencer clears entries 1..N-1
// one per cycle while init_busy stalls the core.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   R_reg1, R_reg2   - read addresses
//   W_reg, W_data    - write address / data
//   Reg_write        - write enable
//   R_data1, R_data2 - read data (combinational)
//   init_busy        - high during reset or while clearing
module reg_file_main
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = cpu_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] R_reg1,
   input  logic [ADDR_W-1:0] R_reg2,
   input  logic [ADDR_W-1:0] W_reg,
   input  logic [DATA_W-1:0] W_data,
   input  logic              Reg_write,
   output logic [DATA_W-1:0] R_data1,
   output logic [DATA_W-1:0] R_data2,
   output logic              init_busy
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   rf_state_t         state, state_nxt;
   logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
   logic              clr_en;
   logic              arr_we;
   logic [DATA_W-1:0] regs [NUM_REGS];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RF_INIT;
         clr_idx <= ADDR_W'(1);
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      if (state == RF_INIT) begin
         if (clr_idx == LAST_IDX) begin
            state_nxt = RF_READY;
         end else begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
         end
      end
   end

   // Output logic
   always_comb begin
      init_busy = reset || (state == RF_INIT);
      clr_en    = !reset && (state == RF_INIT);
      arr_we    = !reset && (state == RF_READY) && Reg_write
                  && (W_reg != ADDR_W'(ZERO_REG));
   end

   // Array: no reset, contents only change via clearing or user writes.
   // Entry 0 is never written; the read ports mask it.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         regs[clr_idx] <= '0;
      end else if (arr_we) begin
         regs[W_reg] <= W_data;
      end
   end

   rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd1 (
      .state  (state),
      .r_reg  (R_reg1),
      .wr_en  (Reg_write),
      .w_reg  (W_reg),
      .w_data (W_data),
      .regs   (regs),
      .r_data (R_data1)
   );

   rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd2 (
      .state  (state),
      .r_reg  (R_reg2),
      .wr_en  (Reg_write),
      .w_reg  (W_reg),
      .w_data (W_data),
      .regs   (regs),
      .r_data (R_data2)
   );

endmodule

// File: tb/tb_reg_file_main.sv
// Self-checking bench for reg_file_main against a behavioural model.
module tb_reg_file_main;
   import cpu_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] R_reg1, R_reg2, W_reg;
   logic [DATA_W-1:0] W_data;
   logic              Reg_write;
   logic [DATA_W-1:0] R_data1, R_data2;
   logic              init_busy;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   // Model: register contents plus number of clearing edges still owed.
   logic [DATA_W-1:0] m_mem [NUM_REGS];
   int                m_left = NUM_REGS - 1;

   reg_file_main #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .R_reg1    (R_reg1),
      .R_reg2    (R_reg2),
      .W_reg     (W_reg),
      .W_data    (W_data),
      .Reg_write (Reg_write),
      .R_data1   (R_data1),
      .R_data2   (R_data2),
      .init_busy (init_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
      if (m_left > 0)                 return '0;
      if (a == 0)                     return '0;
      if (Reg_write && (W_reg == a))  return W_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy();
      return reset || (m_left > 0);
   endfunction

   // Advance model by one edge using the inputs present now, then the DUT.
   task automatic tick();
      if (reset) begin
         m_left = NUM_REGS - 1;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0)
            for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
      end else if (Reg_write && (W_reg != 0)) begin
         m_mem[W_reg] = W_data;
      end
      @(posedge clk);
      #1;
   endtask

   // Ticks until init_busy drops; returns edge count (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      while (init_busy && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1; Reg_write = 1'b0; W_reg = '0; W_data = '0;
      R_reg1 = '0; R_reg2 = '0;
      tick(); tick();
      n_assert++;
      if (init_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 1", init_busy);
      end
      reset = 1'b0; Reg_write = 1'b1; W_reg = 5; W_data = 32'hDEAD_BEEF;
      n = 0;
      while (init_busy && n < 100) begin
         R_reg1 = ADDR_W'($urandom);
         R_reg2 = (n % 4 == 0) ? ADDR_W'(5) : ADDR_W'($urandom);
         #1;
         n_assert++;
         if (R_data1 !== exp_rd(R_reg1) || R_data2 !== exp_rd(R_reg2)
             || R_data1 !== '0 || R_data2 !== '0) begin
            n_fail++;
            $display("FAIL init_read: edge %0d got %h/%h want 0/0", n, R_data1, R_data2);
         end
         tick();
         n++;
      end
      n_assert++;
      if (n != NUM_REGS - 1) begin
         n_fail++;
         $display("FAIL init_len: got %0d edges want %0d", n, NUM_REGS - 1);
      end
      Reg_write = 1'b0; R_reg1 = 5; R_reg2 = 5;
      #1;
      n_assert++;
      if (R_data1 !== '0 || R_data2 !== exp_rd(R_reg2)) begin
         n_fail++;
         $display("FAIL reg5_after_init: got %h/%h want 0", R_data1, R_data2);
      end
   endtask

   task automatic test_write_read();
      Reg_write = 1'b1; W_reg = 3; W_data = 32'h0000_00A5;
      R_reg1 = 1; R_reg2 = 2;
      tick();
      Reg_write = 1'b0; R_reg1 = 3; R_reg2 = 4;
      #1;
      n_assert++;
      if (R_data1 !== 32'h0000_00A5 || R_data1 !== exp_rd(R_reg1)) begin
         n_fail++;
         $display("FAIL write_read: got %h want 000000a5", R_data1);
      end
      n_assert++;
      if (R_data2 !== '0) begin
         n_fail++;
         $display("FAIL unwritten_read: got %h want 0", R_data2);
      end
   endtask

   task automatic test_bypass();
      Reg_write = 1'b1; W_reg = 7; W_data = 32'h1234_5678;
      R_reg1 = 7; R_reg2 = 7;
      #1;
      n_assert++;
      if (R_data1 !== 32'h1234_5678 || R_data2 !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL bypass: got %h/%h want 12345678", R_data1, R_data2);
      end
      tick();
      Reg_write = 1'b0; W_data = '0;
      #1;
      n_assert++;
      if (R_data1 !== 32'h1234_5678 || R_data2 !== exp_rd(7)) begin
         n_fail++;
         $display("FAIL bypass_stored: got %h/%h want 12345678", R_data1, R_data2);
      end
   endtask

   task automatic test_zero_reg();
      Reg_write = 1'b1; W_reg = 0; W_data = 32'hFFFF_FFFF;
      R_reg1 = 0; R_reg2 = 0;
      #1;
      n_assert++;
      if (R_data1 !== '0 || R_data2 !== '0) begin
         n_fail++;
         $display("FAIL zero_bypass: got %h/%h want 0", R_data1, R_data2);
      end
      tick();
      Reg_write = 1'b0;
      #1;
      n_assert++;
      if (R_data1 !== '0 || R_data2 !== '0) begin
         n_fail++;
         $display("FAIL zero_after: got %h/%h want 0", R_data1, R_data2);
      end
   endtask

   task automatic test_reset_mid_init();
      int n;
      // reg 3 still holds a5 from earlier
      reset = 1'b1; Reg_write = 1'b0; tick();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1; tick();      // 10th clearing edge
      reset = 1'b0;
      n_assert++;
      if (init_busy !== 1'b1 || init_busy !== exp_busy()) begin
         n_fail++;
         $display("FAIL midinit_busy: got %b want 1", init_busy);
      end
      wait_ready(n);
      n_assert++;
      if (n != NUM_REGS - 1) begin
         n_fail++;
         $display("FAIL midinit_len: got %0d edges want %0d", n, NUM_REGS - 1);
      end
      R_reg1 = 3; R_reg2 = 7;
      #1;
      n_assert++;
      if (R_data1 !== '0 || R_data2 !== exp_rd(7) || R_data2 !== '0) begin
         n_fail++;
         $display("FAIL midinit_cleared: got %h/%h want 0/0", R_data1, R_data2);
      end
   endtask

   task automatic test_reset_ready();
      int n;
      Reg_write = 1'b1; W_reg = 9; W_data = 32'hCAFE_F00D;
      tick();
      Reg_write = 1'b0; R_reg1 = 9;
      #1;
      n_assert++;
      if (R_data1 !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL pre_reset_val: got %h want cafef00d", R_data1);
      end
      reset = 1'b1; Reg_write = 1'b1; W_reg = 9; W_data = 32'h1;
      tick();
      reset = 1'b0; Reg_write = 1'b0;
      wait_ready(n);
      n_assert++;
      if (n != NUM_REGS - 1) begin
         n_fail++;
         $display("FAIL ready_reset_len: got %0d edges want %0d", n, NUM_REGS - 1);
      end
      R_reg1 = 9; R_reg2 = 9;
      #1;
      n_assert++;
      if (R_data1 !== '0 || R_data2 !== '0) begin
         n_fail++;
         $display("FAIL ready_reset_val: got %h/%h want 0", R_data1, R_data2);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         Reg_write = 1'($urandom);
         W_reg     = ADDR_W'($urandom);
         W_data    = $urandom;
         R_reg1    = ($urandom_range(0, 3) == 0) ? W_reg : ADDR_W'($urandom);
         R_reg2    = ($urandom_range(0, 3) == 0) ? W_reg : ADDR_W'($urandom);
         #1;
         n_assert++;
         if (R_data1 !== exp_rd(R_reg1) || R_data2 !== exp_rd(R_reg2)
             || init_busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL random_rd: cyc %0d a=%0d/%0d got %h/%h busy %b want %h/%h busy %b",
                     c, R_reg1, R_reg2, R_data1, R_data2, init_busy,
                     exp_rd(R_reg1), exp_rd(R_reg2), exp_busy());
         end
         tick();
      end
      Reg_write = 1'b0;
   endtask

   task automatic test_back_to_back();
      // Consecutive writes to one address, reading it every cycle
      for (int c = 0; c < 8; c++) begin
         Reg_write = 1'b1; W_reg = 12; W_data = 32'h100 + c;
         R_reg1 = 12; R_reg2 = 12;
         #1;
         n_assert++;
         if (R_data1 !== 32'h100 + c || R_data2 !== 32'h100 + c) begin
            n_fail++;
            $display("FAIL b2b: cyc %0d got %h/%h want %h", c, R_data1, R_data2, 32'h100 + c);
         end
         tick();
      end
      Reg_write = 1'b0;
      #1;
      n_assert++;
      if (R_data1 !== 32'h107) begin
         n_fail++;
         $display("FAIL b2b_final: got %h want 00000107", R_data1);
      end
   endtask

   initial begin
      reset = 1'b1; Reg_write = 1'b0; W_reg = '0; W_data = '0;
      R_reg1 = '0; R_reg2 = '0;
      for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_reset_mid_init();
      test_back_to_back();
      test_random();
      test_reset_ready();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_main.md
Name: reg_file_main

Overview:
- Register file that sources the operand pair R_data1/R_data2 consumed by the datapath ALU, and accepts the write-back of ALU_Result.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass.
- After reset, a hardware init sequencer clears the array one entry per cycle. This models an SRAM-style array without a parallel reset; init_busy stalls the core until clearing finishes.

Parameters:
DATA_W, 32, data width of each register and of all data ports
ADDR_W, 5, register address width
NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
R_reg1  input  ADDR_W  read address, port 1
R_reg2  input  ADDR_W  read address, port 2
W_reg  input  ADDR_W  write address
W_data  input  DATA_W  write data (ALU_Result or load data)
Reg_write  input  1  write enable
R_data1  output  DATA_W  read data, port 1 (combinational)
R_data2  output  DATA_W  read data, port 2 (combinational)
init_busy  output  1  high while reset is asserted or clearing is in progress

Behaviour:
- Only one clock; reset is synchronous and active-high. Nothing happens on reset except at a clk rising edge.
- FSM states:
  - INIT: clearing.
  - READY: normal operation.
- Init counter clr_idx is ADDR_W bits wide.
- Reset:
  - At any edge with reset=1: state<=INIT, clr_idx<=1.
  - Array contents are not touched on that edge.
  - init_busy=1 whenever reset=1 or state==INIT (combinational from state and reset).
- INIT, at each edge with reset=0:
  - reg[clr_idx]<=0.
  - If clr_idx==NUM_REGS-1, state<=READY; else clr_idx<=clr_idx+1.
  - Clearing takes exactly NUM_REGS-1 edges (31 at defaults). init_busy falls after the 31st edge.
- During INIT:
  - Reg_write is ignored; no user write reaches the array.
  - R_data1 and R_data2 are forced to 0.
- READY, write:
  - At an edge with Reg_write=1 and W_reg!=0: reg[W_reg]<=W_data.
  - Writes with W_reg==0 are discarded.
- READY, read, evaluated per port n in priority order:
  1. R_regn==0 -> 0.
  2. Reg_write=1 and W_reg==R_regn -> W_data (bypass; visible in the same cycle the write is presented).
  3. Otherwise -> reg[R_regn].
- Both ports may read the same address, including the bypassed address; both return identical values.
- Write latency: a write is visible in the array from the cycle after the edge, and via bypass in the cycle it is presented.
- Reset mid-INIT: the sequence restarts at clr_idx=1. Entries already cleared remain 0.
- Reset in READY: all entries are re-cleared by a full new sequence. No user-visible data survives once init_busy falls.
- Reset has priority over an INIT-to-READY transition and over any Reg_write on the same edge.
- Widths: no arithmetic on data; clr_idx compares against NUM_REGS-1 without wrap. Counter overflow cannot occur because the transition to READY happens first.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - ZERO_REG address constant (0).
  - rf_state_t enum {RF_INIT, RF_READY}.
  - The package is also to be used by the ALU and control blocks for data width.
- One natural sub-module: rf_read_port. It holds the zero-check, bypass and array-select mux, and is instantiated twice (ports 1 and 2), driven by the array, the write port signals and the state.
- FSM, counter and array live in reg_file_main.

Test Plan:
- Reset for 2 cycles, then release. Required:
  - init_busy=1 for exactly 31 edges after release, then 0.
  - During init, R_data1=R_data2=0 for every address, even with Reg_write=1, W_reg=5, W_data=32'hDEADBEEF.
  - After init, reg 5 reads 0.
- READY: write W_reg=3, W_data=32'h0000_00A5. Next cycle, R_reg1=3 -> R_data1=32'h0000_00A5. R_reg2=4 -> 0.
- Bypass: same cycle, Reg_write=1, W_reg=7, W_data=32'h1234_5678, R_reg1=R_reg2=7 -> both outputs 32'h1234_5678 before the edge. Array holds it afterwards.
- Zero register: write W_reg=0, W_data=32'hFFFF_FFFF. Then R_reg1=0 -> 0, both in the bypass cycle and afterwards.
- Reset mid-INIT: assert reset at clearing edge 10 of 31, release. Required: init_busy high for a further full 31 edges. Previously written reg 3 (written before the first reset) reads 0 after ready.
- Reset in READY with reg 9=32'hCAFE_F00D: reset with Reg_write=1 on the same edge writing W_reg=9, W_data=1. Required: write discarded, init reruns, reg 9 reads 0 after init_busy falls.
